decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered WISC-SP13 decode stage sitting between the IF/ID and ID/EX boundaries.
- Derives the instruction format internally from the opcode, so no external type input is needed.
- Extracts read, write and link register fields, the write enable and the extended immediate, and passes the incremented PC alongside.
- Elastic valid/ready handshake on both sides with a one-entry skid buffer, synchronous flush, and a saturating backpressure-stall counter.

Parameters:
- DATA_W, 16, width of immed and PC fields; must be ≥16; all extensions fill to DATA_W.
- REG_AW, 3, register index width; instruction fields beyond 3 bits are zero-extended.
- LINK_REG, 7, destination index for JAL/JALR.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- flush  input  1  synchronous; discards all held and incoming instructions.
- in_valid  input  1  an instruction is presented.
- in_ready  output  1  stage can accept; equals ~skid_valid.
- in_instr  input  16  instruction word.
- in_pc  input  DATA_W  incremented PC.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  downstream accepts.
- out_rd1  output  REG_AW  source register 1; 0 if unused.
- out_rd2  output  REG_AW  source register 2; 0 if unused.
- out_wr  output  REG_AW  destination register; 0 if we=0.
- out_we  output  1  register write enable.
- out_immed  output  DATA_W  extended immediate; 0 for R-format and no-operand ops.
- out_pc  output  DATA_W  in_pc carried through.
- out_opcode  output  5  instr[15:11].
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
Reset
- rst=0 immediately clears out_valid, skid_valid, all out_* fields and stall_cnt. in_ready=1 after reset.
- Reset mid-transfer drops all held instructions.

Handshake
- Accept occurs when in_valid & in_ready. Transfer occurs when out_valid & out_ready.
- Latency is 1 cycle: an instruction accepted at edge N appears with out_valid=1 after edge N when the output register is empty or transferring.
- If the output register holds an entry and out_ready=0, an accepted instruction goes to the skid register; in_ready drops next cycle.
- On a transfer with skid_valid=1, the skid entry moves to the output register and in_ready returns to 1 the next cycle.
- Order is strictly preserved.
- out_* fields are stable while out_valid & ~out_ready.
- flush=1 clears out_valid and skid_valid next edge; an instruction accepted in the same cycle is discarded. flush has priority over accept and transfer.
- stall_cnt increments only when flush=0.

Decode (combinational on the input, registered into output or skid)
- J-format: J 00100, JAL 00110.
  - immed = sign-extend instr[10:0].
  - JAL: wr=LINK_REG, we=1.
- I1-format: ADDI/SUBI/XORI/ANDNI 010xx, ROLI/SLLI/RORI/SRLI 101xx, ST 10000, LD 10001, STU 10011.
  - rd1=instr[10:8].
  - immed = 5-bit instr[4:0], zero-extended for XORI, ANDNI and the 101xx shifts; sign-extended otherwise.
  - ST/STU: rd2=instr[7:5].
  - STU: wr=instr[10:8], we=1.
  - ST: we=0.
  - All other I1 ops: wr=instr[7:5], we=1.
- I2-format: LBI 11000, SLBI 10010, BEQZ/BNEZ/BLTZ/BGEZ 011xx, JR 00101, JALR 00111.
  - rd1=instr[10:8].
  - immed = 8-bit instr[7:0], zero-extended for SLBI only.
  - LBI/SLBI: wr=instr[10:8], we=1.
  - JALR: wr=LINK_REG, we=1.
  - Branches and JR: we=0.
- R-format: BTR 11001, 11010, 11011, 111xx.
  - rd1=instr[10:8], wr=instr[4:2], we=1, immed=0.
  - rd2=instr[7:5] except for BTR (rd2=0).
- HALT 00000, NOP 00001, SIIC 00010, RTI 00011: rd1=rd2=wr=0, we=0, immed=0.

Test Plan:
- Push 0x415D (ADDI r2,r1,-3), out_ready=1 → next cycle out_valid=1, rd1=1, wr=2, we=1, immed=0xFFFD, opcode=01000.
- Push 0x37FF (JAL -1) with in_pc=0x0042 → wr=7, we=1, immed=0xFFFF, out_pc=0x0042.
- Push 0x5470 (XORI r3,r4,0x10) → rd1=4, wr=3, immed=0x0010. Push 0x8120 (ST r1,r1,0) → rd1=1, rd2=1, we=0.
- out_ready=0, push A, B, C back-to-back → A held on output, B in skid, in_ready=0, C not accepted. Hold 4 cycles → stall_cnt=4. Raise out_ready → A, B, C emerge in order.
- Output and skid both full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input not emitted.
- Drive rst=0 asynchronously mid-stall → out_valid=0, stall_cnt=0, in_ready=1 without a clock edge. Preload stall_cnt to all-ones with CNT_W=4 → counter holds at 0xF.

Source files
------------

// File: rtl/decode_stage.sv
// WISC-SP13 decode stage: decodes an instruction word into register fields, write
// enable and extended immediate, registered behind an elastic handshake with a skid slot.
module decode_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = 7,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd1,
  output logic [REG_AW-1:0] out_rd2,
  output logic [REG_AW-1:0] out_wr,
  output logic              out_we,
  output logic [DATA_W-1:0] out_immed,
  output logic [DATA_W-1:0] out_pc,
  output logic [4:0]        out_opcode,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a word is accepted on a rising edge where in_valid & in_ready, and
  // leaves on a rising edge where out_valid & out_ready. in_valid/out_valid must not
  // depend on the opposite ready; the stage only refuses input while the skid slot is full.

  localparam int EW = 5 + 3 * REG_AW + 1 + 2 * DATA_W;

  logic [4:0]        opc;
  logic [REG_AW-1:0] f_a, f_b, f_c, link;
  logic [DATA_W-1:0] sx11, sx8, zx8, sx5, zx5;
  logic [REG_AW-1:0] dec_rd1, dec_rd2, dec_wr;
  logic              dec_we;
  logic [DATA_W-1:0] dec_immed;
  logic [EW-1:0]     dec_entry, out_entry, skid_entry;
  logic              skid_valid;
  logic              accept, xfer;

  assign opc  = in_instr[15:11];
  assign f_a  = REG_AW'(in_instr[10:8]);
  assign f_b  = REG_AW'(in_instr[7:5]);
  assign f_c  = REG_AW'(in_instr[4:2]);
  assign link = REG_AW'(LINK_REG);
  assign sx11 = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};
  assign sx8  = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
  assign zx8  = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
  assign sx5  = {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
  assign zx5  = {{(DATA_W-5){1'b0}}, in_instr[4:0]};

  // Format is implied by the opcode; unlisted fields stay zero.
  always_comb begin
    dec_rd1   = '0;
    dec_rd2   = '0;
    dec_wr    = '0;
    dec_we    = 1'b0;
    dec_immed = '0;
    casez (opc)
      5'b00100: dec_immed = sx11;
      5'b00110: begin dec_immed = sx11; dec_wr = link; dec_we = 1'b1; end
      5'b01000, 5'b01001, 5'b10001: begin
        dec_rd1 = f_a; dec_wr = f_b; dec_we = 1'b1; dec_immed = sx5;
      end
      5'b01010, 5'b01011, 5'b101??: begin
        dec_rd1 = f_a; dec_wr = f_b; dec_we = 1'b1; dec_immed = zx5;
      end
      5'b10000: begin dec_rd1 = f_a; dec_rd2 = f_b; dec_immed = sx5; end
      5'b10011: begin
        dec_rd1 = f_a; dec_rd2 = f_b; dec_wr = f_a; dec_we = 1'b1; dec_immed = sx5;
      end
      5'b11000: begin dec_rd1 = f_a; dec_wr = f_a; dec_we = 1'b1; dec_immed = sx8; end
      5'b10010: begin dec_rd1 = f_a; dec_wr = f_a; dec_we = 1'b1; dec_immed = zx8; end
      5'b011??, 5'b00101: begin dec_rd1 = f_a; dec_immed = sx8; end
      5'b00111: begin dec_rd1 = f_a; dec_wr = link; dec_we = 1'b1; dec_immed = sx8; end
      5'b11001: begin dec_rd1 = f_a; dec_wr = f_c; dec_we = 1'b1; end
      5'b11010, 5'b11011, 5'b111??: begin
        dec_rd1 = f_a; dec_rd2 = f_b; dec_wr = f_c; dec_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign dec_entry = {opc, dec_rd1, dec_rd2, dec_wr, dec_we, dec_immed, in_pc};
  assign {out_opcode, out_rd1, out_rd2, out_wr, out_we, out_immed, out_pc} = out_entry;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || xfer) begin
      // Skid holds the older word, and input is refused while it is full.
      if (skid_valid) begin
        out_entry  <= skid_entry;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_entry <= dec_entry;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_entry <= dec_entry;
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (!flush && out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
